// File: rtl/flit_pattern_injector.sv
// Walking-thermometer flit source for datapath energy characterisation.
// Emits packets of PAYLOAD flits, each followed by GAP_CYCLES idle cycles,
// with valid/ready backpressure, packet counting, abort and idle-drive control.
module flit_pattern_injector #(
    parameter int N           = 18,
    parameter int STEP_BITS   = 8,
    parameter int PAYLOAD     = 20,
    parameter int GAP_CYCLES  = 7,
    parameter int NUM_PACKETS = 10,
    parameter int HOLD_IDLE   = 1,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [N-1:0]     op_a,
    output logic [N-1:0]     op_b,
    output logic             window,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] flit_cnt,
    output logic [CNT_W-1:0] pkt_cnt
);
    localparam int W     = 2 * N;
    localparam int F     = (W - 1) / STEP_BITS;
    localparam int L     = 2 * F + 1;
    localparam int IDX_W = $clog2(L + 1);
    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(L - 1);
    localparam logic [CNT_W-1:0] FLIT_LAST = CNT_W'(PAYLOAD - 1);
    localparam logic [CNT_W-1:0] PKT_TOTAL = CNT_W'(NUM_PACKETS);
    localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(GAP_CYCLES - 1);
    localparam bit               FINITE    = (NUM_PACKETS != 0);
    localparam bit               HAS_GAP   = (GAP_CYCLES > 0);
    localparam bit               HOLD      = (HOLD_IDLE != 0);

    // Thermometer entry: 0 = all zeros, 1..F grow from the top, F+1..2F shrink at the bottom.
    function automatic logic [W-1:0] pattern(input logic [IDX_W-1:0] idx);
        logic [W-1:0] ones;
        int           i;
        ones = '1;
        i    = int'(idx);
        if (i == 0)
            return '0;
        else if (i <= F)
            return ~(ones >> (i * STEP_BITS));
        else
            return ~(ones << ((L - i) * STEP_BITS));
    endfunction

    logic [1:0]       state_q, state_d;
    logic             valid_q, valid_d;
    logic [W-1:0]     op_q, op_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] flit_cnt_q, flit_cnt_d;
    logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;

    logic [IDX_W-1:0] idx_next;
    logic [CNT_W-1:0] pkt_next;
    logic [W-1:0]     idle_op;
    logic             accept;

    assign idx_next = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    assign pkt_next = pkt_cnt_q + 1'b1;
    assign idle_op  = HOLD ? op_q : '0;
    assign accept   = valid_q && out_ready;

    // Next-state: stop overrides everything; otherwise run the packet/gap sequencer.
    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        op_d       = op_q;
        idx_d      = idx_q;
        flit_cnt_d = flit_cnt_q;
        pkt_cnt_d  = pkt_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        if (stop) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            op_d    = idle_op;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d    = S_SEND;
                        valid_d    = 1'b1;
                        idx_d      = IDX_FIRST;
                        op_d       = pattern(IDX_FIRST);
                        flit_cnt_d = '0;
                        pkt_cnt_d  = '0;
                    end
                end
                S_SEND: begin
                    if (accept) begin
                        if (flit_cnt_q == FLIT_LAST) begin
                            flit_cnt_d = '0;
                            pkt_cnt_d  = pkt_next;
                            if (FINITE && pkt_next == PKT_TOTAL && !HAS_GAP) begin
                                state_d = S_DONE;
                                valid_d = 1'b0;
                                op_d    = idle_op;
                            end else if (HAS_GAP) begin
                                state_d   = S_GAP;
                                valid_d   = 1'b0;
                                op_d      = idle_op;
                                gap_cnt_d = GAP_LOAD;
                            end else begin
                                // back-to-back packet: pattern restarts
                                idx_d = IDX_FIRST;
                                op_d  = pattern(IDX_FIRST);
                            end
                        end else begin
                            flit_cnt_d = flit_cnt_q + 1'b1;
                            idx_d      = idx_next;
                            op_d       = pattern(idx_next);
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt_q == '0) begin
                        if (FINITE && pkt_cnt_q == PKT_TOTAL) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_SEND;
                            valid_d = 1'b1;
                            idx_d   = IDX_FIRST;
                            op_d    = pattern(IDX_FIRST);
                        end
                    end else begin
                        gap_cnt_d = gap_cnt_q - 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            valid_q    <= 1'b0;
            op_q       <= '0;
            idx_q      <= '0;
            flit_cnt_q <= '0;
            pkt_cnt_q  <= '0;
            gap_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            op_q       <= op_d;
            idx_q      <= idx_d;
            flit_cnt_q <= flit_cnt_d;
            pkt_cnt_q  <= pkt_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    assign out_valid = valid_q;
    assign op_a      = op_q[N-1:0];
    assign op_b      = op_q[W-1:N];
    assign window    = (state_q == S_SEND) || (state_q == S_GAP);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign flit_cnt  = flit_cnt_q;
    assign pkt_cnt   = pkt_cnt_q;

endmodule

// File: tb/tb_flit_pattern_injector.sv
// Directed bench for flit_pattern_injector: three instances cover the default
// configuration, back-to-back packets (no gap) and zero idle drive.
module tb_flit_pattern_injector;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
    logic stop = 1'b0;
    logic ready = 1'b1;

    logic        v0, w0, b0, d0;
    logic [17:0] a0, ob0;
    logic [15:0] f0, p0;
    logic        v1, w1, b1, d1;
    logic [17:0] a1, ob1;
    logic [15:0] f1, p1;
    logic        v2, w2, b2, d2;
    logic [17:0] a2, ob2;
    logic [15:0] f2, p2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    flit_pattern_injector u0 (
        .clk(clk), .rst(rst), .start(start0), .stop(stop), .out_ready(ready),
        .out_valid(v0), .op_a(a0), .op_b(ob0), .window(w0), .busy(b0), .done(d0),
        .flit_cnt(f0), .pkt_cnt(p0));

    flit_pattern_injector #(.GAP_CYCLES(0), .NUM_PACKETS(2)) u1 (
        .clk(clk), .rst(rst), .start(start1), .stop(stop), .out_ready(ready),
        .out_valid(v1), .op_a(a1), .op_b(ob1), .window(w1), .busy(b1), .done(d1),
        .flit_cnt(f1), .pkt_cnt(p1));

    flit_pattern_injector #(.HOLD_IDLE(0), .NUM_PACKETS(1)) u2 (
        .clk(clk), .rst(rst), .start(start2), .stop(stop), .out_ready(ready),
        .out_valid(v2), .op_a(a2), .op_b(ob2), .window(w2), .busy(b2), .done(d2),
        .flit_cnt(f2), .pkt_cnt(p2));

    typedef struct {
        logic        start;
        logic        rdy;
        logic        stp;
        logic        exp_valid;
        logic        exp_busy;
        logic [17:0] exp_a;
        logic [17:0] exp_b;
        logic [15:0] exp_fcnt;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(logic s, logic r, logic p, logic v, logic b,
                                logic [17:0] ea, logic [17:0] eb, logic [15:0] fc);
        vec_t t;
        t.start = s; t.rdy = r; t.stp = p; t.exp_valid = v; t.exp_busy = b;
        t.exp_a = ea; t.exp_b = eb; t.exp_fcnt = fc;
        return t;
    endfunction

    vec_t tbl[18];

    initial begin
        int acc, c, val_err, hold_err, done_cnt, done_cyc, zero_err;
        logic [17:0] last_a, last_b;

        // start, ready, stop | valid, busy, op_a, op_b, flit_cnt (after the edge)
        tbl[0]  = mk(1, 1, 0, 1, 1, 18'h00000, 18'h3FC00, 0);
        tbl[1]  = mk(0, 1, 0, 1, 1, 18'h00000, 18'h3FFFC, 1);
        tbl[2]  = mk(0, 1, 0, 1, 1, 18'h3F000, 18'h3FFFF, 2);
        tbl[3]  = mk(0, 1, 0, 1, 1, 18'h3FFF0, 18'h3FFFF, 3);
        tbl[4]  = mk(0, 1, 0, 1, 1, 18'h3FFFF, 18'h03FFF, 4);
        tbl[5]  = mk(0, 1, 0, 1, 1, 18'h3FFFF, 18'h0003F, 5);
        tbl[6]  = mk(0, 1, 0, 1, 1, 18'h0FFFF, 18'h00000, 6);
        tbl[7]  = mk(0, 1, 0, 1, 1, 18'h000FF, 18'h00000, 7);
        tbl[8]  = mk(0, 1, 0, 1, 1, 18'h00000, 18'h00000, 8);
        tbl[9]  = mk(0, 1, 0, 1, 1, 18'h00000, 18'h3FC00, 9);
        tbl[10] = mk(0, 1, 1, 0, 0, 18'h00000, 18'h3FC00, 9);
        tbl[11] = mk(1, 1, 0, 1, 1, 18'h00000, 18'h3FC00, 0);
        tbl[12] = mk(0, 1, 0, 1, 1, 18'h00000, 18'h3FFFC, 1);
        tbl[13] = mk(0, 1, 0, 1, 1, 18'h3F000, 18'h3FFFF, 2);
        tbl[14] = mk(0, 0, 0, 1, 1, 18'h3F000, 18'h3FFFF, 2);
        tbl[15] = mk(0, 0, 0, 1, 1, 18'h3F000, 18'h3FFFF, 2);
        tbl[16] = mk(0, 0, 0, 1, 1, 18'h3F000, 18'h3FFFF, 2);
        tbl[17] = mk(0, 1, 0, 1, 1, 18'h3FFF0, 18'h3FFFF, 3);

        // reset state
        #3;
        check("rst_valid", v0, 0);
        check("rst_ops", {a0, ob0}, 0);
        check("rst_flags", {w0, b0, d0}, 0);
        check("rst_cnts", {f0, p0}, 0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // pattern walk, stop, stall under backpressure
        for (int i = 0; i < 18; i++) begin
            start0 = tbl[i].start;
            ready  = tbl[i].rdy;
            stop   = tbl[i].stp;
            step();
            start0 = 1'b0;
            stop   = 1'b0;
            check($sformatf("v%0d_valid", i), v0, tbl[i].exp_valid);
            check($sformatf("v%0d_busy", i), b0, tbl[i].exp_busy);
            check($sformatf("v%0d_op_a", i), a0, tbl[i].exp_a);
            check($sformatf("v%0d_op_b", i), ob0, tbl[i].exp_b);
            check($sformatf("v%0d_fcnt", i), f0, tbl[i].exp_fcnt);
        end
        // rest of the stalled packet: flits 3..19
        ready = 1'b1;
        acc = 0;
        for (int i = 0; i < 40 && v0; i++) begin
            acc++;
            step();
        end
        check("stall_rest_flits", acc, 17);
        check("stall_pkt_cnt", p0, 1);
        check("stall_fcnt", f0, 0);
        check("stall_gap_window", {w0, v0}, 2'b10);
        stop = 1'b1; step(); stop = 1'b0;

        // free-running default run
        start0 = 1'b1; step(); start0 = 1'b0;
        val_err = 0; hold_err = 0; done_cnt = 0; done_cyc = -1;
        last_a = a0; last_b = ob0;
        for (c = 1; c <= 280; c++) begin
            if (c <= 270 && v0 !== (((c - 1) % 27) < 20)) val_err++;
            if (v0) begin
                last_a = a0; last_b = ob0;
            end else if (c <= 270 && (a0 !== last_a || ob0 !== last_b)) hold_err++;
            if (d0) begin
                done_cnt++;
                done_cyc = c;
            end
            step();
        end
        check("run_valid_shape", val_err, 0);
        check("run_gap_hold", hold_err, 0);
        check("run_done_count", done_cnt, 1);
        check("run_done_cycle", done_cyc, 271);
        check("run_pkt_cnt", p0, 10);
        check("run_busy_end", b0, 0);

        // back-to-back packets, no gap
        start1 = 1'b1; step(); start1 = 1'b0;
        val_err = 0;
        for (c = 1; c <= 40; c++) begin
            if (!v1) val_err++;
            if (c == 21) begin
                check("b2b_flit20_op_b", ob1, 18'h3FC00);
                check("b2b_flit20_op_a", a1, 0);
                check("b2b_flit20_cnts", {f1, p1}, {16'd0, 16'd1});
            end
            step();
        end
        check("b2b_valid_40", val_err, 0);
        check("b2b_done", {d1, v1}, 2'b10);
        check("b2b_pkt_cnt", p1, 2);
        step();
        check("b2b_idle", b1, 0);

        // zero idle drive
        start2 = 1'b1; step(); start2 = 1'b0;
        for (c = 1; c < 21; c++) step();
        zero_err = 0;
        for (c = 21; c <= 27; c++) begin
            if (v2 || a2 != 0 || ob2 != 0 || !w2) zero_err++;
            step();
        end
        check("zero_gap_ops", zero_err, 0);
        check("zero_done", {d2, a2, ob2}, {1'b1, 36'd0});
        step();
        check("zero_idle", {b2, a2, ob2}, 0);

        // stop at flit 5 of packet 3
        start0 = 1'b1; step(); start0 = 1'b0;
        for (c = 1; c < 60; c++) step();
        check("pre_stop_fcnt", {v0, f0, p0}, {1'b1, 16'd5, 16'd2});
        stop = 1'b1; step(); stop = 1'b0;
        check("stop_flags", {v0, w0, b0, d0}, 0);
        check("stop_cnts", {f0, p0}, {16'd5, 16'd2});
        done_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            if (d0 || b0) done_cnt++;
            step();
        end
        check("stop_quiet", done_cnt, 0);
        check("stop_cnt_frozen", {f0, p0}, {16'd5, 16'd2});

        // stop beats start
        start0 = 1'b1; stop = 1'b1; step(); start0 = 1'b0; stop = 1'b0;
        check("stop_over_start", b0, 0);

        // async reset mid-gap
        start0 = 1'b1; step(); start0 = 1'b0;
        for (c = 1; c < 22; c++) step();
        check("pre_rst_gap", {w0, v0, p0}, {2'b10, 16'd1});
        #2 rst = 1'b1;
        #1;
        check("rst_async_flags", {v0, w0, b0, d0}, 0);
        check("rst_async_ops", {a0, ob0}, 0);
        check("rst_async_cnts", {f0, p0}, 0);
        @(negedge clk);
        rst = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/flit_pattern_injector.md
Name: flit_pattern_injector

Overview:
- Synthesizable, parametrised stimulus source for energy characterization of datapath blocks (adders first).
- Generates packets of PAYLOAD flits. Each flit is a 2N-bit walking thermometer pattern split into two N-bit operands.
- Each packet is followed by GAP_CYCLES idle cycles, which sets link utilisation.
- Sits in front of the unit under test and exposes a measurement window flag for switching-activity capture.
- Adds valid/ready backpressure, packet counting, abort and idle-drive mode.

Parameters:
- N, 18, operand width; the pattern width W = 2*N.
- STEP_BITS, 8, thermometer step in bits; legal range 1 to W-1.
- PAYLOAD, 20, flits per packet; must be at least 1.
- GAP_CYCLES, 7, idle cycles after each packet; 0 is legal.
- NUM_PACKETS, 10, packets per run; 0 means run until stop.
- HOLD_IDLE, 1, outside SEND: 1 holds the last operands, 0 drives zero.
- CNT_W, 16, width of the flit and packet counters.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to begin a run; sampled only in IDLE
- stop  in  1  abort; effective in any state
- out_ready  in  1  downstream accepts the flit
- out_valid  out  1  op_a/op_b carry a flit
- op_a  out  N  pattern[N-1:0]
- op_b  out  N  pattern[2N-1:N]
- window  out  1  high in SEND and GAP (capture window)
- busy  out  1  state is not IDLE
- done  out  1  one-cycle pulse at normal run completion
- flit_cnt  out  CNT_W  flits accepted in the current packet
- pkt_cnt  out  CNT_W  packets completed in this run

Behaviour:
- Reset values: state=IDLE, all outputs 0, pattern index 0.
- Pattern sequence:
  - F = floor((W-1)/STEP_BITS); the sequence has L = 2F+1 entries.
  - idx 0: all zeros.
  - idx 1..F: top-aligned ones, count idx*STEP_BITS.
  - idx F+1..2F: bottom-aligned ones, count (2F+1-idx)*STEP_BITS.
  - Flit j (0-based) of every packet uses idx (j+1) mod L. The index restarts at the start of each packet.
- FSM states: IDLE, SEND, GAP, DONE.
  - IDLE: start=1 -> SEND. The first flit is presented with out_valid=1 on the next cycle.
  - SEND: a flit is accepted when out_valid && out_ready. On acceptance, advance idx and increment flit_cnt. If out_ready=0, outputs and idx hold; there is no drop and no skip.
  - SEND exit: after flit PAYLOAD-1 is accepted, pkt_cnt increments and flit_cnt clears.
    - If pkt_cnt reaches NUM_PACKETS (NUM_PACKETS != 0) and GAP_CYCLES = 0 -> DONE.
    - Otherwise, if GAP_CYCLES > 0 -> GAP.
    - Otherwise -> SEND, with the next packet's first flit on the following cycle.
  - GAP: out_valid=0 for exactly GAP_CYCLES cycles. Then -> DONE if pkt_cnt == NUM_PACKETS (NUM_PACKETS != 0), else -> SEND.
  - DONE: done=1 for one cycle -> IDLE. pkt_cnt holds its final value until the next start.
- Counters:
  - start clears pkt_cnt and flit_cnt.
  - With NUM_PACKETS=0, pkt_cnt wraps modulo 2^CNT_W and the run continues.
- Idle drive (outside SEND): HOLD_IDLE=1 holds op_a/op_b at the last presented flit; HOLD_IDLE=0 drives 0.
- stop in any state:
  - Next cycle: IDLE, out_valid=0, window=0, no done pulse.
  - Counters freeze.
  - stop has priority over start and over the handshake in the same cycle.
- start while busy is ignored.
- Asynchronous rst mid-packet: immediate return to reset values.
- out_valid is registered and does not depend combinationally on out_ready.

Test Plan:
1. Defaults, out_ready=1, start pulse.
   - Flit 0: op_b=0x3FC00, op_a=0. Flit 1: op_b=0x3FFFC, op_a=0. Flit 2: op_b=0x3FFFF, op_a=0x3F000.
   - Flit 4: op_a=0x3FFFF, op_b=0x03FFF. Flit 8: both 0.
   - Flit 9 repeats flit 0.
2. Defaults, free-running.
   - 20 valid cycles, then 7 invalid cycles with operands held, per packet.
   - After 10 packets: done pulses once at cycle 271 after start.
   - Then pkt_cnt=10, busy=0.
3. out_ready low for 3 cycles during flit 2: op_a/op_b stable at 0x3F000/0x3FFFF for those cycles. Flit 3 appears only after acceptance. Total flits per packet is still 20.
4. GAP_CYCLES=0, NUM_PACKETS=2: 40 back-to-back valid cycles. The pattern restarts at 0x3FC00 for flit 20. done follows the 40th acceptance.
5. HOLD_IDLE=0: op_a=op_b=0 in every GAP cycle and after DONE.
6. stop asserted at flit 5 of packet 3: out_valid=0 next cycle, no done pulse, pkt_cnt=2. rst mid-GAP returns all outputs to 0 immediately.
